id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the five-stage pipeline. Drives the register file read addresses from the decoded instruction and resolves each operand by forwarding from EX, MEM or WB before falling back to register file data. It detects load-use hazards, asserts a stall and inserts a bubble, and captures operands and control into the ID/EX pipeline register. Downstream the EX stage consumes the register; upstream the IF/ID register obeys `stall`.

---
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: resolves operands through EX/MEM/WB forwarding,
// detects load-use hazards and holds the ID/EX pipeline register.
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_wena,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_use_imm,
    input  logic [3:0]        id_alu_op,

    output logic [ADDR_W-1:0] r0addr,
    output logic [ADDR_W-1:0] r1addr,
    input  logic [DATA_W-1:0] r0data,
    input  logic [DATA_W-1:0] r1data,

    input  logic              exf_wena,
    input  logic [ADDR_W-1:0] exf_waddr,
    input  logic [DATA_W-1:0] exf_wdata,
    input  logic              exf_memread,
    input  logic              memf_wena,
    input  logic [ADDR_W-1:0] memf_waddr,
    input  logic [DATA_W-1:0] memf_wdata,
    input  logic              wbf_wena,
    input  logic [ADDR_W-1:0] wbf_waddr,
    input  logic [DATA_W-1:0] wbf_wdata,

    input  logic              flush,
    output logic              stall,

    output logic              ex_valid,
    output logic              ex_wena,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_use_imm,
    output logic [3:0]        ex_alu_op,
    output logic [ADDR_W-1:0] ex_waddr,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm
);

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              hz;
    logic              bubble;

    // Youngest producer wins; r0 always reads the register file.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_val,
        input logic              e_we,
        input logic [ADDR_W-1:0] e_wa,
        input logic [DATA_W-1:0] e_wd,
        input logic              m_we,
        input logic [ADDR_W-1:0] m_wa,
        input logic [DATA_W-1:0] m_wd,
        input logic              w_we,
        input logic [ADDR_W-1:0] w_wa,
        input logic [DATA_W-1:0] w_wd
    );
        logic [DATA_W-1:0] val;
        val = rf_val;
        if (src == '0)
            val = rf_val;
        else if (e_we && (e_wa == src))
            val = e_wd;
        else if (m_we && (m_wa == src))
            val = m_wd;
        else if (w_we && (w_wa == src))
            val = w_wd;
        return val;
    endfunction

    assign r0addr = id_rs;
    assign r1addr = id_rt;

    always_comb begin
        fwd_a = resolve(id_rs, r0data,
                        exf_wena, exf_waddr, exf_wdata,
                        memf_wena, memf_waddr, memf_wdata,
                        wbf_wena, wbf_waddr, wbf_wdata);
        fwd_b = resolve(id_rt, r1data,
                        exf_wena, exf_waddr, exf_wdata,
                        memf_wena, memf_waddr, memf_wdata,
                        wbf_wena, wbf_waddr, wbf_wdata);
    end

    // Load data only exists after MEM, so a consumer directly behind a load waits one cycle.
    always_comb begin
        hz = id_valid & ex_valid & exf_memread & ex_wena & (ex_waddr != '0) &
             ((id_rs_used & (id_rs == ex_waddr)) | (id_rt_used & (id_rt == ex_waddr)));
        stall  = hz & ~flush;
        bubble = flush | hz | ~id_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_wena     <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_use_imm  <= 1'b0;
            ex_alu_op   <= '0;
            ex_waddr    <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_wena     <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_use_imm  <= 1'b0;
            ex_alu_op   <= '0;
            ex_waddr    <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_wena     <= id_wena & (id_rd != '0);
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_use_imm  <= id_use_imm;
            ex_alu_op   <= id_alu_op;
            ex_waddr    <= id_rd;
            ex_a        <= fwd_a;
            ex_b        <= fwd_b;
            ex_imm      <= id_imm;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, load-use stall,
// r0 protection, flush and asynchronous reset.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_rs_used, id_rt_used;
    logic [63:0] id_imm;
    logic        id_wena, id_memread, id_memwrite, id_use_imm;
    logic [3:0]  id_alu_op;
    logic [4:0]  r0addr, r1addr;
    logic [63:0] r0data, r1data;
    logic        exf_wena, exf_memread;
    logic [4:0]  exf_waddr;
    logic [63:0] exf_wdata;
    logic        memf_wena;
    logic [4:0]  memf_waddr;
    logic [63:0] memf_wdata;
    logic        wbf_wena;
    logic [4:0]  wbf_waddr;
    logic [63:0] wbf_wdata;
    logic        flush, stall;
    logic        ex_valid, ex_wena, ex_memread, ex_memwrite, ex_use_imm;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_waddr;
    logic [63:0] ex_a, ex_b, ex_imm;

    int total = 0;
    int bad   = 0;

    logic [63:0] rf [32];

    // Register file model: register i holds the value i (r0 = 0).
    assign r0data = rf[r0addr];
    assign r1data = rf[r1addr];

    id_ex_stage #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_imm(id_imm),
        .id_wena(id_wena), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .r0addr(r0addr), .r1addr(r1addr), .r0data(r0data), .r1data(r1data),
        .exf_wena(exf_wena), .exf_waddr(exf_waddr), .exf_wdata(exf_wdata),
        .exf_memread(exf_memread),
        .memf_wena(memf_wena), .memf_waddr(memf_waddr), .memf_wdata(memf_wdata),
        .wbf_wena(wbf_wena), .wbf_waddr(wbf_waddr), .wbf_wdata(wbf_wdata),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_wena(ex_wena), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_use_imm(ex_use_imm), .ex_alu_op(ex_alu_op),
        .ex_waddr(ex_waddr), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic rs_u, input logic rt_u,
                                 input logic [63:0] imm, input logic we, input logic mr,
                                 input logic mw, input logic ui, input logic [3:0] op);
        id_valid = v;    id_rs = rs;        id_rt = rt;         id_rd = rd;
        id_rs_used = rs_u; id_rt_used = rt_u; id_imm = imm;
        id_wena = we;    id_memread = mr;   id_memwrite = mw;   id_use_imm = ui;
        id_alu_op = op;
    endtask

    task automatic clear_fwd();
        exf_wena = 0;  exf_waddr = 0;  exf_wdata = 0;  exf_memread = 0;
        memf_wena = 0; memf_waddr = 0; memf_wdata = 0;
        wbf_wena = 0;  wbf_waddr = 0;  wbf_wdata = 0;
    endtask

    // Puts "ld rd" into EX and drives the EX-stage view of it.
    task automatic load_into_ex(input logic [4:0] rd);
        clear_fwd();
        applyStimulus(1, 5'd1, 5'd0, rd, 1, 0, 64'h8, 1, 1, 0, 1, 4'h0);
        step();
        exf_wena = (rd != 0); exf_waddr = rd; exf_wdata = 64'hDEAD; exf_memread = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_fwd();
        flush = 0;
        applyStimulus(1, 5'd3, 5'd0, 5'd7, 1, 1, 64'h55, 1, 0, 0, 0, 4'h2);
        #12;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", ex_valid); end
        total++; if (ex_a !== 64'h0) begin bad++; $display("[TB] FAIL reset_a: got %h want 0", ex_a); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        total++; if (r0addr !== 5'd3 || r1addr !== 5'd0) begin bad++; $display("[TB] FAIL raddr: got %0d/%0d want 3/0", r0addr, r1addr); end
        #1 rst_n = 1;
    endtask

    task automatic test_no_hazard();
        applyStimulus(1, 5'd3, 5'd0, 5'd7, 1, 1, 64'h1234, 1, 0, 0, 0, 4'h5);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL nohz_stall: got %b want 0", stall); end
        step();
        total++; if (ex_a !== 64'd3) begin bad++; $display("[TB] FAIL nohz_a: got %h want 3", ex_a); end
        total++; if (ex_b !== 64'd0) begin bad++; $display("[TB] FAIL nohz_b: got %h want 0", ex_b); end
        total++; if (ex_waddr !== 5'd7 || ex_valid !== 1'b1 || ex_wena !== 1'b1) begin bad++; $display("[TB] FAIL nohz_ctl: got waddr=%0d v=%b we=%b want 7/1/1", ex_waddr, ex_valid, ex_wena); end
        total++; if (ex_imm !== 64'h1234 || ex_alu_op !== 4'h5) begin bad++; $display("[TB] FAIL nohz_imm_op: got %h/%h want 1234/5", ex_imm, ex_alu_op); end
        applyStimulus(1, 5'd2, 5'd6, 5'd0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 1, 4'hA);
        step();
        total++; if (ex_a !== 64'd2 || ex_b !== 64'd6) begin bad++; $display("[TB] FAIL store_ops: got %h/%h want 2/6", ex_a, ex_b); end
        total++; if (ex_memwrite !== 1'b1 || ex_use_imm !== 1'b1 || ex_memread !== 1'b0 || ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0) begin bad++; $display("[TB] FAIL store_ctl: got mw=%b ui=%b mr=%b imm=%h", ex_memwrite, ex_use_imm, ex_memread, ex_imm); end
    endtask

    task automatic test_forward_priority();
        exf_wena = 1;  exf_waddr = 5;  exf_wdata = 64'h11;
        memf_wena = 1; memf_waddr = 5; memf_wdata = 64'h22;
        wbf_wena = 1;  wbf_waddr = 5;  wbf_wdata = 64'h33;
        applyStimulus(1, 5'd5, 5'd5, 5'd1, 1, 1, 64'h0, 1, 0, 0, 0, 4'h1);
        step();
        total++; if (ex_a !== 64'h11 || ex_b !== 64'h11) begin bad++; $display("[TB] FAIL fwd_ex: got %h/%h want 11", ex_a, ex_b); end
        exf_wena = 0;
        step();
        total++; if (ex_a !== 64'h22 || ex_b !== 64'h22) begin bad++; $display("[TB] FAIL fwd_mem: got %h/%h want 22", ex_a, ex_b); end
        memf_wena = 0;
        step();
        total++; if (ex_a !== 64'h33 || ex_b !== 64'h33) begin bad++; $display("[TB] FAIL fwd_wb: got %h/%h want 33", ex_a, ex_b); end
        wbf_wena = 0;
        step();
        total++; if (ex_a !== 64'h5) begin bad++; $display("[TB] FAIL fwd_rf: got %h want 5", ex_a); end
        id_valid = 0;
        step();
        total++; if (ex_valid !== 1'b0 || ex_a !== 64'h0 || ex_waddr !== 5'd0) begin bad++; $display("[TB] FAIL invalid_bubble: got v=%b a=%h wa=%0d want 0", ex_valid, ex_a, ex_waddr); end
        clear_fwd();
    endtask

    task automatic test_load_use();
        load_into_ex(5'd4);
        total++; if (ex_memread !== 1'b1 || ex_waddr !== 5'd4) begin bad++; $display("[TB] FAIL load_capture: got mr=%b wa=%0d want 1/4", ex_memread, ex_waddr); end
        applyStimulus(1, 5'd4, 5'd2, 5'd8, 1, 1, 64'h0, 1, 0, 0, 0, 4'h3);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall: got %b want 1", stall); end
        step();
        total++; if (ex_valid !== 1'b0 || ex_wena !== 1'b0 || ex_a !== 64'h0) begin bad++; $display("[TB] FAIL lu_bubble: got v=%b we=%b a=%h want 0", ex_valid, ex_wena, ex_a); end
        clear_fwd();
        memf_wena = 1; memf_waddr = 4; memf_wdata = 64'hABCD;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_release: got %b want 0", stall); end
        step();
        total++; if (ex_a !== 64'hABCD || ex_b !== 64'd2 || ex_valid !== 1'b1 || ex_waddr !== 5'd8) begin bad++; $display("[TB] FAIL lu_forward: got a=%h b=%h v=%b wa=%0d", ex_a, ex_b, ex_valid, ex_waddr); end
    endtask

    task automatic test_false_hazard();
        load_into_ex(5'd4);
        applyStimulus(1, 5'd4, 5'd5, 5'd8, 0, 1, 64'h0, 1, 0, 0, 0, 4'h0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL fh_rs_unused: got %b want 0", stall); end
        id_rs = 5'd6; id_rt = 5'd4; id_rt_used = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL fh_rt_unused: got %b want 0", stall); end
        id_rt_used = 1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL hz_rt_used: got %b want 1", stall); end
        load_into_ex(5'd0);
        total++; if (ex_wena !== 1'b0 || ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL ld_r0_ctl: got we=%b v=%b want 0/1", ex_wena, ex_valid); end
        applyStimulus(1, 5'd0, 5'd0, 5'd8, 1, 1, 64'h0, 1, 0, 0, 0, 4'h0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL ld_r0_stall: got %b want 0", stall); end
        clear_fwd();
    endtask

    task automatic test_r0_protect();
        exf_wena = 1; exf_waddr = 0; exf_wdata = 64'hFF;
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 64'h0, 1, 0, 0, 0, 4'h1);
        step();
        total++; if (ex_a !== 64'h0 || ex_b !== 64'h0) begin bad++; $display("[TB] FAIL r0_fwd: got %h/%h want 0", ex_a, ex_b); end
        total++; if (ex_wena !== 1'b0 || ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL r0_wena: got we=%b v=%b want 0/1", ex_wena, ex_valid); end
        clear_fwd();
    endtask

    task automatic test_flush_reset();
        applyStimulus(1, 5'd9, 5'd3, 5'd2, 1, 1, 64'h7, 1, 0, 0, 0, 4'h4);
        flush = 1;
        step();
        total++; if (ex_valid !== 1'b0 || ex_a !== 64'h0 || ex_imm !== 64'h0) begin bad++; $display("[TB] FAIL flush_bubble: got v=%b a=%h imm=%h want 0", ex_valid, ex_a, ex_imm); end
        flush = 0;
        load_into_ex(5'd4);
        applyStimulus(1, 5'd4, 5'd0, 5'd9, 1, 0, 64'h0, 1, 0, 0, 0, 4'h0);
        flush = 1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall: got %b want 0", stall); end
        step();
        total++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0) begin bad++; $display("[TB] FAIL flush_hz_bubble: got v=%b mr=%b want 0", ex_valid, ex_memread); end
        flush = 0;
        load_into_ex(5'd4);
        applyStimulus(1, 5'd4, 5'd0, 5'd9, 1, 0, 64'h0, 1, 0, 0, 0, 4'h0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_stall: got %b want 1", stall); end
        #2 rst_n = 0;
        #1;
        total++; if (ex_valid !== 1'b0 || ex_wena !== 1'b0 || ex_memread !== 1'b0 || ex_waddr !== 5'd0 || ex_use_imm !== 1'b0 || ex_imm !== 64'h0) begin bad++; $display("[TB] FAIL async_reset: got v=%b we=%b mr=%b wa=%0d", ex_valid, ex_wena, ex_memread, ex_waddr); end
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall_drop: got %b want 0", stall); end
        #1 rst_n = 1;
        clear_fwd();
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'(i);
        test_reset();
        test_no_hazard();
        test_forward_priority();
        test_load_use();
        test_false_hazard();
        test_r0_protect();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
